bin_to_bcd_seq: RTL

- Sequential shift-and-add-3 (double-dabble) converter that turns a binary value from the processor datapath (register, ALU result, PC) into packed BCD digits.
- Sits directly upstream of the per-digit 4-bit-to-7-segment decoders. Their outputs feed the 8-digit LED multiplexer.
- Runs one bit per clock with a start/busy/done handshake, so it needs no wide combinational divider.

---
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: binary in, packed BCD out, one bit per clock.
// Results that need more than DIGITS decimal digits are shown as all-F with overflow set.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_nxt;
    logic [IN_WIDTH-1:0] shreg, shreg_nxt;
    logic [BCD_W-1:0]    scratch, scratch_nxt;
    logic [BCD_W-1:0]    adjusted;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                sticky, sticky_nxt;
    logic [BCD_W-1:0]    bcd_nxt;
    logic                overflow_nxt;
    logic                done_nxt;
    logic                last_shift;

    assign busy       = (state == SHIFT);
    assign last_shift = (count == CNT_W'(IN_WIDTH - 1));

    // Add-3 correction on every digit (including the top one), no carry between digits
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update; result registers only move on the final shift
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        scratch_nxt  = scratch;
        count_nxt    = count;
        sticky_nxt   = sticky;
        bcd_nxt      = bcd_out;
        overflow_nxt = overflow;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt   = bin_in;
                    scratch_nxt = '0;
                    sticky_nxt  = 1'b0;
                    count_nxt   = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_nxt, shreg_nxt} = {adjusted, shreg} << 1;
                sticky_nxt = sticky | adjusted[BCD_W-1];
                count_nxt  = count + 1'b1;
                if (last_shift) begin
                    bcd_nxt      = sticky_nxt ? '1 : scratch_nxt;
                    overflow_nxt = sticky_nxt;
                    done_nxt     = 1'b1;
                    count_nxt    = '0;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous active-low clear abandons any conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            count    <= '0;
            sticky   <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            scratch  <= scratch_nxt;
            count    <= count_nxt;
            sticky   <= sticky_nxt;
            bcd_out  <= bcd_nxt;
            overflow <= overflow_nxt;
            done     <= done_nxt;
        end
    end

endmodule
